// File: rtl/inst_fetch_unit.sv
`timescale 1ns/1ps
// RV32 instruction fetch: PC, single-outstanding imem reads, one-entry output buffer
// toward decode, redirect/squash handling and fault entries.
//
// state | meaning
// REQ   | issue read at pc (or post misaligned fault)
// WAIT  | read accepted, waiting for response
// DRAIN | one stale response outstanding after redirect, discard it
// STALL | fault entry posted, idle until redirect
module inst_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    input  logic            imem_resp_err,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_access_fault,
    output logic            inst_misaligned
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2,
        S_STALL = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            inst_valid_q, inst_valid_d;
    logic [ILEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            afault_q, afault_d;
    logic            misal_q, misal_d;
    logic            pc_aligned;
    logic            req_fire;

    assign pc_aligned     = (pc_q[1:0] == 2'b00);
    assign imem_req_valid = (state_q == S_REQ) && pc_aligned && !inst_valid_q;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign inst_valid        = inst_valid_q;
    assign inst              = inst_q;
    assign inst_pc           = inst_pc_q;
    assign inst_access_fault = afault_q;
    assign inst_misaligned   = misal_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        afault_d     = afault_q;
        misal_d      = misal_q;

        if (inst_valid_q && inst_ready) begin
            inst_valid_d = 1'b0;
        end

        // A redirect squashes the buffer even if decode takes it this cycle.
        if (redirect_valid) begin
            pc_d         = redirect_pc;
            inst_valid_d = 1'b0;
            unique case (state_q)
                S_REQ:   state_d = req_fire ? S_DRAIN : S_REQ;
                S_WAIT:  state_d = imem_resp_valid ? S_REQ : S_DRAIN;
                S_DRAIN: state_d = S_DRAIN;
                S_STALL: state_d = S_REQ;
                default: state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (!pc_aligned) begin
                        if (!inst_valid_q) begin
                            inst_valid_d = 1'b1;
                            inst_d       = '0;
                            inst_pc_d    = pc_q;
                            afault_d     = 1'b0;
                            misal_d      = 1'b1;
                            state_d      = S_STALL;
                        end
                    end else if (req_fire) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        inst_valid_d = 1'b1;
                        inst_pc_d    = pc_q;
                        afault_d     = imem_resp_err;
                        misal_d      = 1'b0;
                        if (imem_resp_err) begin
                            inst_d  = '0;
                            state_d = S_STALL;
                        end else begin
                            inst_d  = imem_resp_data;
                            pc_d    = pc_q + XLEN'(4);
                            state_d = S_REQ;
                        end
                    end
                end
                S_DRAIN: begin
                    if (imem_resp_valid) begin
                        state_d = S_REQ;
                    end
                end
                S_STALL: state_d = S_STALL;
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            afault_q     <= 1'b0;
            misal_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            afault_q     <= afault_d;
            misal_q      <= misal_d;
        end
    end

endmodule
